fc_result_writer: RTL and testbench



---
 rtl/fc_pkg.sv | 31 +++
 rtl/fc_result_writer.sv | 129 ++++++++++++
 tb/tb_fc_result_writer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected stage: word/address widths,
// layer sizes, FCmemory region map, writer FSM states and the ReLU helper.
package fc_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 14;

    // Layer sizes
    localparam int FC_IN_NODES = 120;
    localparam int FC1_NODES   = 84;
    localparam int FC2_NODES   = 10;

    // FCmemory region base addresses
    localparam int INPUTS_BASE   = 0;
    localparam int WEIGHTS1_BASE = 120;
    localparam int BIASES1_BASE  = 10200;
    localparam int OUTPUTS1_BASE = 10284;

    // Result writer FSM states
    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wb_state_t;

    // Clamp a signed fixed-point word at zero
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/fc_result_writer.sv
// Write-back engine for the fully-connected stage. On start it captures the
// layer's packed output-node vector and writes it into FCmemory one word per
// clock starting at BASE_ADDR, then pulses done.
// Optional feature macro: FC_WB_RELU_EN -- when defined, each word is clamped
// to max(node, 0) on the buffer read path (no extra latency).
module fc_result_writer #(
    parameter int NUM_NODES = fc_pkg::FC1_NODES,
    parameter int DATA_W    = fc_pkg::DATA_W,
    parameter int ADDR_W    = fc_pkg::ADDR_W,
    parameter int BASE_ADDR = fc_pkg::OUTPUTS1_BASE
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_NODES*DATA_W-1:0] nodes_in,
    output logic [ADDR_W-1:0]           address,
    output logic [DATA_W-1:0]           data_in,
    output logic                        write_enable,
    output logic                        read_enable,
    output logic                        busy,
    output logic                        done
);
    import fc_pkg::*;

    localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    if (BASE_ADDR + NUM_NODES > (1 << ADDR_W)) begin : g_addr_range_check
        $error("fc_result_writer: BASE_ADDR + NUM_NODES exceeds the FCmemory address space");
    end

    wb_state_t                   state;
    wb_state_t                   state_next;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            idx_next;
    logic [NUM_NODES*DATA_W-1:0] node_buffer;
    logic [DATA_W-1:0]           rd_word;
    logic [DATA_W-1:0]           wr_word;
    logic [ADDR_W-1:0]           address_next;
    logic [DATA_W-1:0]           data_next;
    logic                        we_next;
    logic                        busy_next;
    logic                        done_next;

    // This block only ever writes, so the read strobe stays low
    assign read_enable = 1'b0;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE, never queued
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = WRITE;
            WRITE:   if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Index of the word that will be on the bus next cycle
    always_comb begin
        idx_next = idx;
        if (state == IDLE && start) begin
            idx_next = '0;
        end else if (state == WRITE && idx != LAST_IDX) begin
            idx_next = idx + 1'b1;
        end
    end

    // Word 0 comes straight from nodes_in since the buffer loads on the same edge
    always_comb begin
        if (state == IDLE) begin
            rd_word = nodes_in[int'(idx_next)*DATA_W +: DATA_W];
        end else begin
            rd_word = node_buffer[int'(idx_next)*DATA_W +: DATA_W];
        end
    end

`ifdef FC_WB_RELU_EN
    assign wr_word = relu(rd_word);
`else
    assign wr_word = rd_word;
`endif

    // Output logic: next values of the registered outputs, keyed off the next state
    always_comb begin
        we_next      = (state_next == WRITE);
        busy_next    = (state_next == WRITE);
        done_next    = (state_next == DONE);
        address_next = address;
        data_next    = data_in;
        if (state_next == WRITE) begin
            address_next = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_next);
            data_next    = wr_word;
        end
    end

    // Registered outputs, word counter and node buffer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            node_buffer  <= '0;
            address      <= '0;
            data_in      <= '0;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            idx          <= idx_next;
            address      <= address_next;
            data_in      <= data_next;
            write_enable <= we_next;
            busy         <= busy_next;
            done         <= done_next;
            if (state == IDLE && start) begin
                node_buffer <= nodes_in;
            end
        end
    end

endmodule

// File: tb/tb_fc_result_writer.sv
// Self-checking bench for fc_result_writer: an FC1-sized instance (84 nodes)
// and an FC2-sized instance (10 nodes). Expected writes are queued when a
// burst is started and popped by a monitor on every observed write strobe.
module tb_fc_result_writer;

    localparam int NA = 84;
    localparam int BA = 10284;
    localparam int NB = 10;
    localparam int BB = 11220;
    localparam int DW = 16;
    localparam int AW = 14;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_a;
    logic           start_b;
    logic [NA*DW-1:0] nodes_a;
    logic [NB*DW-1:0] nodes_b;
    logic [AW-1:0]  address_a;
    logic [AW-1:0]  address_b;
    logic [DW-1:0]  data_a;
    logic [DW-1:0]  data_b;
    logic           we_a, re_a, busy_a, done_a;
    logic           we_b, re_b, busy_b, done_b;

    int errors   = 0;
    int checks   = 0;
    int writes_a = 0;
    int writes_b = 0;

    logic [31:0]   q_a[$];
    logic [31:0]   q_b[$];
    logic [DW-1:0] mem_a[int];

    fc_result_writer #(
        .NUM_NODES(NA), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BA)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .nodes_in(nodes_a),
        .address(address_a), .data_in(data_a), .write_enable(we_a),
        .read_enable(re_a), .busy(busy_a), .done(done_a)
    );

    fc_result_writer #(
        .NUM_NODES(NB), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BB)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .nodes_in(nodes_b),
        .address(address_b), .data_in(data_b), .write_enable(we_b),
        .read_enable(re_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // Value the memory should receive for a given node
    function automatic logic [DW-1:0] exp_word(input logic [DW-1:0] x);
`ifdef FC_WB_RELU_EN
        return x[DW-1] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor for the FC1 instance; a write with nothing queued
    // is compared against an impossible sentinel
    always @(negedge clk) begin
        logic [31:0] exp;
        if (we_a === 1'b1) begin
            exp = (q_a.size() != 0) ? q_a.pop_front() : 32'hFFFF_FFFF;
            check_output("A_write", {2'b00, address_a, data_a}, exp);
            mem_a[int'(address_a)] = data_a;
            writes_a++;
        end
    end

    // Scoreboard monitor for the FC2 instance
    always @(negedge clk) begin
        logic [31:0] exp;
        if (we_b === 1'b1) begin
            exp = (q_b.size() != 0) ? q_b.pop_front() : 32'hFFFF_FFFF;
            check_output("B_write", {2'b00, address_b, data_b}, exp);
            writes_b++;
        end
    end

    task automatic apply_stimulus_a();
        @(posedge clk);
        #1;
        start_a = 1'b1;
        for (int k = 0; k < NA; k++) begin
            q_a.push_back({2'b00, AW'(BA + k), exp_word(nodes_a[k*DW +: DW])});
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    // Cycle-by-cycle timing check of one burst; optionally re-pulses start
    // (with scrambled nodes) mid-burst, which must have no effect
    task automatic run_burst_a(input int pulse_at);
        for (int c = 1; c <= NA + 1; c++) begin
            @(negedge clk);
            check_output("A_busy", {31'b0, busy_a}, 32'(c <= NA));
            check_output("A_write_enable", {31'b0, we_a}, 32'(c <= NA));
            check_output("A_done", {31'b0, done_a}, 32'(c == NA + 1));
            check_output("A_read_enable", {31'b0, re_a}, 32'd0);
            if (c == pulse_at) begin
                #1;
                start_a = 1'b1;
                nodes_a = ~nodes_a;
            end
            if (pulse_at != 0 && c == pulse_at + 1) begin
                #1;
                start_a = 1'b0;
            end
        end
        check_output("A_all_written", q_a.size(), 32'd0);
    endtask

    task automatic check_idle_a(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            check_output({tag, "_write_enable"}, {31'b0, we_a}, 32'd0);
            check_output({tag, "_done"}, {31'b0, done_a}, 32'd0);
            check_output({tag, "_busy"}, {31'b0, busy_a}, 32'd0);
        end
    endtask

    initial begin
        int w0;
        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        nodes_a = '0;
        nodes_b = '0;
        $display("[TB] starting fc_result_writer bench");

        // Reset state of both instances
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_address_a", {18'b0, address_a}, 32'd0);
        check_output("rst_data_a", {16'b0, data_a}, 32'd0);
        check_output("rst_we_a", {31'b0, we_a}, 32'd0);
        check_output("rst_re_a", {31'b0, re_a}, 32'd0);
        check_output("rst_busy_a", {31'b0, busy_a}, 32'd0);
        check_output("rst_done_a", {31'b0, done_a}, 32'd0);
        check_output("rst_address_b", {18'b0, address_b}, 32'd0);
        check_output("rst_we_b", {31'b0, we_b}, 32'd0);
        check_output("rst_done_b", {31'b0, done_b}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic burst: node k = k+1
        for (int k = 0; k < NA; k++) nodes_a[k*DW +: DW] = DW'(k + 1);
        apply_stimulus_a();
        run_burst_a(0);
        check_output("basic_first_word", {16'b0, mem_a[BA]}, 32'd1);
        check_output("basic_last_word", {16'b0, mem_a[BA + NA - 1]}, 32'd84);

        // Back-to-back: start in the IDLE cycle right after done
        for (int k = 0; k < NA; k++) nodes_a[k*DW +: DW] = DW'(16'h2000 + k);
        apply_stimulus_a();
        run_burst_a(0);

        // Ignored start mid-burst, with nodes_in scrambled at the same time
        check_idle_a("post_b2b", 1);
        for (int k = 0; k < NA; k++) nodes_a[k*DW +: DW] = DW'(16'h1000 + 3 * k);
        w0 = writes_a;
        apply_stimulus_a();
        run_burst_a(10);
        check_output("ignored_start_count", writes_a - w0, NA);
        check_idle_a("post_ignore", 3);

        // Reset mid-burst: everything clears at once and no done follows
        for (int k = 0; k < NA; k++) nodes_a[k*DW +: DW] = DW'(16'h3000 + k);
        apply_stimulus_a();
        for (int c = 1; c <= 40; c++) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("midrst_address", {18'b0, address_a}, 32'd0);
        check_output("midrst_data", {16'b0, data_a}, 32'd0);
        check_output("midrst_we", {31'b0, we_a}, 32'd0);
        check_output("midrst_busy", {31'b0, busy_a}, 32'd0);
        check_output("midrst_done", {31'b0, done_a}, 32'd0);
        q_a.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle_a("post_reset", 3);
        apply_stimulus_a();
        run_burst_a(0);

        // ReLU boundary: node 3 negative, node 4 positive
        for (int k = 0; k < NA; k++) nodes_a[k*DW +: DW] = DW'(k + 1);
        nodes_a[3*DW +: DW] = 16'hFF00;
        nodes_a[4*DW +: DW] = 16'h0100;
        apply_stimulus_a();
        run_burst_a(0);
`ifdef FC_WB_RELU_EN
        check_output("relu_neg_word", {16'b0, mem_a[10287]}, 32'h0000);
`else
        check_output("relu_neg_word", {16'b0, mem_a[10287]}, 32'hFF00);
`endif
        check_output("relu_pos_word", {16'b0, mem_a[10288]}, 32'h0100);

        // FC2 sizing on the second instance
        for (int k = 0; k < NB; k++) nodes_b[k*DW +: DW] = DW'(16'h0A00 + k);
        @(posedge clk);
        #1;
        start_b = 1'b1;
        for (int k = 0; k < NB; k++) begin
            q_b.push_back({2'b00, AW'(BB + k), exp_word(nodes_b[k*DW +: DW])});
        end
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int c = 1; c <= NB + 2; c++) begin
            @(negedge clk);
            check_output("B_busy", {31'b0, busy_b}, 32'(c <= NB));
            check_output("B_write_enable", {31'b0, we_b}, 32'(c <= NB));
            check_output("B_done", {31'b0, done_b}, 32'(c == NB + 1));
            check_output("B_read_enable", {31'b0, re_b}, 32'd0);
        end
        check_output("B_all_written", q_b.size(), 32'd0);
        check_output("B_write_count", writes_b, NB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
